// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state codes,
// register-number width and the load-use hazard test.
package pipe_ctrl_pkg;

   localparam int unsigned STATE_W = 2;
   localparam int unsigned REG_W   = 5;

   typedef enum logic [STATE_W-1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_HALT  = 2'd2,
      ST_ILL   = 2'd3
   } state_t;

   // True when the ID instruction reads the register a load in EX is about to write.
   function automatic logic load_use_hazard(
      input logic             ex_memread,
      input logic [REG_W-1:0] ex_rd,
      input logic [REG_W-1:0] id_rs,
      input logic [REG_W-1:0] id_rt,
      input logic             id_use_rs,
      input logic             id_use_rt
   );
      return ex_memread && (ex_rd != REG_W'(0)) &&
             ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));
   endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter used for the front-panel pipeline statistics.
module pipe_sat_counter #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             in_CLK,
   input  logic             in_CLR,
   input  logic             in_inc,
   output logic [CNT_W-1:0] out_cnt
);

   // Count increments, sticking at the all-ones value instead of wrapping.
   always_ff @(posedge in_CLK or posedge in_CLR) begin
      if (in_CLR) begin
         out_cnt <= '0;
      end else if (in_inc && (out_cnt != {CNT_W{1'b1}})) begin
         out_cnt <= out_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control for the 5-stage CPU: PC / IF/ID / ID/EX enables and flushes,
// load-use stalls, branch/jump flushes and the drain-freeze-resume halt sequence.
// Define PIPE_STATS_EN to build the saturating statistics counters; otherwise the
// counter outputs are tied to zero.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned DRAIN_CYCLES = 3,
   parameter int unsigned CNT_W        = 32
) (
   input  logic               in_CLK,
   input  logic               in_CLR,
   input  logic [REG_W-1:0]   in_id_rs,
   input  logic [REG_W-1:0]   in_id_rt,
   input  logic               in_id_use_rs,
   input  logic               in_id_use_rt,
   input  logic               in_ex_memread,
   input  logic [REG_W-1:0]   in_ex_rd,
   input  logic               in_ex_br_taken,
   input  logic               in_id_jump,
   input  logic               in_id_halt,
   input  logic               in_go,
   output logic               out_pc_en,
   output logic               out_ifid_en,
   output logic               out_ifid_flush,
   output logic               out_idex_flush,
   output logic               out_halted,
   output logic [STATE_W-1:0] out_state,
   output logic [CNT_W-1:0]   out_cyc_cnt,
   output logic [CNT_W-1:0]   out_stall_cnt,
   output logic [CNT_W-1:0]   out_flush_cnt
);

   // Drain counter holds DRAIN_CYCLES-1 down to 0.
   localparam int unsigned DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   state_t           state;
   state_t           state_nxt;
   logic [DRN_W-1:0] drn_cnt;
   logic [DRN_W-1:0] drn_nxt;
   logic             halted_q;
   logic             hazard;
   logic             pc_en_c;
   logic             ifid_en_c;
   logic             ifid_flush_c;
   logic             idex_flush_c;

   assign hazard = load_use_hazard(in_ex_memread, in_ex_rd, in_id_rs, in_id_rt,
                                   in_id_use_rs, in_id_use_rt);

   // State, drain counter and halted flag registers.
   always_ff @(posedge in_CLK or posedge in_CLR) begin
      if (in_CLR) begin
         state    <= ST_RUN;
         drn_cnt  <= '0;
         halted_q <= 1'b0;
      end else begin
         state    <= state_nxt;
         drn_cnt  <= drn_nxt;
         halted_q <= (state_nxt == ST_HALT);
      end
   end

   // Next-state and strobe decode; branch beats load-use beats halt beats jump in RUN.
   always_comb begin
      state_nxt    = state;
      drn_nxt      = drn_cnt;
      pc_en_c      = 1'b0;
      ifid_en_c    = 1'b0;
      ifid_flush_c = 1'b0;
      idex_flush_c = 1'b0;
      case (state)
         ST_RUN: begin
            if (in_ex_br_taken) begin
               // Wrong-path halt/jump in ID is squashed along with everything else.
               pc_en_c      = 1'b1;
               ifid_en_c    = 1'b1;
               ifid_flush_c = 1'b1;
               idex_flush_c = 1'b1;
            end else if (hazard) begin
               idex_flush_c = 1'b1;
            end else if (in_id_halt) begin
               idex_flush_c = 1'b1;
               state_nxt    = ST_DRAIN;
               drn_nxt      = DRN_W'(DRAIN_CYCLES - 1);
            end else if (in_id_jump) begin
               pc_en_c      = 1'b1;
               ifid_en_c    = 1'b1;
               ifid_flush_c = 1'b1;
            end else begin
               pc_en_c      = 1'b1;
               ifid_en_c    = 1'b1;
            end
         end
         ST_DRAIN: begin
            idex_flush_c = 1'b1;
            if (drn_cnt == '0) begin
               state_nxt = ST_HALT;
            end else begin
               drn_nxt = drn_cnt - DRN_W'(1);
            end
         end
         ST_HALT: begin
            // Resume: clear the held halt out of IF/ID so the next capture is halt+1.
            if (in_go) begin
               ifid_flush_c = 1'b1;
               idex_flush_c = 1'b1;
               state_nxt    = ST_RUN;
            end
         end
         default: begin
            state_nxt = ST_RUN;
            drn_nxt   = '0;
         end
      endcase
   end

   assign out_pc_en      = pc_en_c      & ~in_CLR;
   assign out_ifid_en    = ifid_en_c    & ~in_CLR;
   assign out_ifid_flush = ifid_flush_c & ~in_CLR;
   assign out_idex_flush = idex_flush_c & ~in_CLR;
   assign out_halted     = halted_q;
   assign out_state      = state;

`ifdef PIPE_STATS_EN
   logic cyc_inc;
   logic stall_inc;
   logic flush_inc;

   assign cyc_inc   = (state == ST_RUN) || (state == ST_DRAIN);
   assign stall_inc = (state == ST_RUN) && !in_ex_br_taken && hazard;
   assign flush_inc = (state == ST_RUN) && ifid_flush_c;

   pipe_sat_counter #(.CNT_W(CNT_W)) u_cyc_cnt (
      .in_CLK (in_CLK),
      .in_CLR (in_CLR),
      .in_inc (cyc_inc),
      .out_cnt(out_cyc_cnt)
   );

   pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .in_CLK (in_CLK),
      .in_CLR (in_CLR),
      .in_inc (stall_inc),
      .out_cnt(out_stall_cnt)
   );

   pipe_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .in_CLK (in_CLK),
      .in_CLR (in_CLR),
      .in_inc (flush_inc),
      .out_cnt(out_flush_cnt)
   );
`else
   assign out_cyc_cnt   = '0;
   assign out_stall_cnt = '0;
   assign out_flush_cnt = '0;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline control unit for the 5-stage CPU: produces the enable and flush strobes for the PC, IF/ID and ID/EX pipeline registers. Handles load-use stalls, branch/jump flushes, and a halt sequence: drain, freeze, resume on `in_go`. Optionally keeps saturating performance counters for the front-panel display. Sits beside the IF/ID register and drives its enable input directly.

## Interface
- `DRAIN_CYCLES`, default 3: cycles the pipeline runs after a halt is accepted in ID, before freezing (covers EX, MEM and WB).
- `CNT_W`, default 32: width of each statistics counter.
- `in_CLK` in 1: clock.
- `in_CLR` in 1: reset, asynchronous, active-high.
- `in_id_rs`, `in_id_rt` in 5 each: source register numbers of the instruction in ID.
- `in_id_use_rs`, `in_id_use_rt` in 1 each: the ID instruction actually reads that source.
- `in_ex_memread` in 1: the EX instruction is a load.
- `in_ex_rd` in 5: destination register of the EX instruction.
- `in_ex_br_taken` in 1: conditional branch resolved taken in EX.
- `in_id_jump` in 1: unconditional jump decoded in ID.
- `in_id_halt` in 1: halt (syscall-halt) decoded in ID.
- `in_go` in 1: resume request, honoured only in HALT.
- `out_pc_en` out 1: PC write enable.
- `out_ifid_en` out 1: IF/ID enable.
- `out_ifid_flush` out 1: synchronous clear request for IF/ID.
- `out_idex_flush` out 1: synchronous bubble insert for ID/EX.
- `out_halted` out 1: high while in HALT.
- `out_state` out 2: current FSM state code.
- `out_cyc_cnt`, `out_stall_cnt`, `out_flush_cnt` out CNT_W each: statistics counters.

## Operation
- FSM states: RUN=0, DRAIN=1, HALT=2. Code 3 is illegal and recovers to RUN on the next edge.
- Load-use hazard: `in_ex_memread` and `in_ex_rd`≠0 and ((`use_rs` and rs==rd) or (`use_rt` and rt==rd)).
- RUN priority, highest first:
  - `in_ex_br_taken`: pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=1.
  - Load-use: pc_en=0, ifid_en=0, idex_flush=1, ifid_flush=0.
  - `in_id_halt`: pc_en=0, ifid_en=0, idex_flush=1; go to DRAIN with drain counter = DRAIN_CYCLES-1.
  - `in_id_jump`: pc_en=1, ifid_en=1, ifid_flush=1.
  - Otherwise: pc_en=1, ifid_en=1, no flushes.
- A halt or jump in ID under a simultaneous taken branch is wrong-path. It is discarded and no DRAIN is entered.
- A halt under a load-use hazard waits; it is accepted once the stall clears.
- DRAIN:
  - pc_en=0, ifid_en=0, idex_flush=1 every cycle.
  - Counter decrements each cycle. At 0 the FSM goes to HALT, so DRAIN lasts exactly DRAIN_CYCLES cycles.
  - DRAIN_CYCLES=1 means a single DRAIN cycle.
- HALT:
  - All enables 0, no flushes, out_halted=1.
  - When `in_go`=1: that cycle drives ifid_flush=1, idex_flush=1, pc_en=0, then goes to RUN.
  - The next IF/ID capture is the instruction after the halt.
- `in_go` is ignored outside HALT.
- While `in_CLR`=1: state=RUN, drain counter=0, all counters=0. All outputs are forced low: pc_en=0, ifid_en=0, both flushes=0, out_halted=0, out_state=0.

## Timing
- Enable and flush outputs are combinational from the current inputs and registered state, and are valid before the next `in_CLK` rising edge.
- Flushes are synchronous requests that take effect at the next edge. The top level must never route them to an asynchronous clear pin.
- State, drain counter and statistics update on the `in_CLK` rising edge.
- out_halted and out_state are registered-state decodes, glitch-free.

## Configuration
- `PIPE_STATS_EN` defined, counters active and saturating at 2^CNT_W-1:
  - `out_cyc_cnt` +1 per cycle in RUN or DRAIN.
  - `out_stall_cnt` +1 per load-use stall cycle.
  - `out_flush_cnt` +1 per cycle with out_ifid_flush=1 in RUN.
- `PIPE_STATS_EN` undefined: counter logic is removed and all three outputs are constant 0. Ports are unchanged.

## Structure
- Package `pipe_ctrl_pkg` holds the state codes (ST_RUN, ST_DRAIN, ST_HALT) and the 2-bit state width.
- Sub-module `pipe_sat_counter` (CNT_W, in_CLK, in_CLR, in_inc, out_cnt) is instantiated three times under `PIPE_STATS_EN`.

## Test plan
- Load-use: ex_memread=1, ex_rd=8, id_rs=8, use_rs=1 for one cycle → pc_en=0, ifid_en=0, idex_flush=1. With PIPE_STATS_EN, stall_cnt=1.
- Load-use is suppressed for ex_rd=0 with id_rs=0, and with use_rs=0 and use_rt=0 → pc_en=1, no flushes.
- Branch priority: ex_br_taken=1, id_halt=1 and a load-use hazard in the same cycle → both flushes=1, pc_en=1, state stays RUN.
- Halt sequence: id_halt=1 in RUN, DRAIN_CYCLES=3 → state=1 for exactly 3 cycles, then out_halted=1. A go=1 in the resume cycle gives ifid_flush=1, pc_en=0, and state=0 next.
- Reset mid-DRAIN: in_CLR pulsed in the 2nd DRAIN cycle → immediately state=0, all outputs 0, counters 0. After release, normal RUN outputs.
- Saturation with CNT_W=4: 20 RUN cycles → cyc_cnt holds 15.
